// File: rtl/memory_unit.sv
// Wait-state memory: accepts one read or write in IDLE, holds it in ACCESS for
// WAIT_CYCLES cycles, commits on the ACCESS->DONE edge, then pulses mfc in DONE.
module memory_unit #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_BITS   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [15:0] mem_data_in,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] mem_data_out,
    output logic        mfc,
    output logic        busy,
    output logic        req_err
);

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t               state;
    state_t               next_state;
    logic [3:0]           wait_cnt;
    logic [ADDR_BITS-1:0] lat_addr;
    logic [15:0]          lat_data;
    logic                 lat_wr;
    logic [15:0]          mem [DEPTH];

    logic accept;
    logic conflict;
    logic finish;
    logic unused_addr_hi;

    assign accept   = (state == IDLE) && (rd ^ wr);
    assign conflict = (state == IDLE) && rd && wr;
    assign finish   = (state == ACCESS) && (wait_cnt == LAST_CNT);

    // Upper address bits alias away; folded into a dummy so they are not flagged unused.
    assign unused_addr_hi = ^(addr >> ADDR_BITS);

    assign mfc  = (state == DONE);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ACCESS;
            ACCESS:  if (finish) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request latches stay frozen from acceptance until the next IDLE acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt     <= 4'd0;
            lat_addr     <= '0;
            lat_data     <= 16'h0000;
            lat_wr       <= 1'b0;
            mem_data_out <= 16'h0000;
            req_err      <= 1'b0;
        end else begin
            req_err <= conflict;
            if (accept) begin
                wait_cnt <= 4'd0;
                lat_addr <= addr[ADDR_BITS-1:0];
                lat_data <= mem_data_in;
                lat_wr   <= wr;
            end else if ((state == ACCESS) && !finish) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (finish && !lat_wr) begin
                mem_data_out <= mem[lat_addr];
            end
        end
    end

    // Storage has no reset so contents survive it; an aborted write never reaches finish.
    always_ff @(posedge clk) begin
        if (finish && lat_wr) begin
            mem[lat_addr] <= lat_data;
        end
    end

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench for memory_unit: table vectors, hand-written corner
// sequences and randomized transfers against an array-based reference model.
module tb_memory_unit;

    localparam int WAIT = 2;
    localparam int ABITS = 8;
    localparam int DEPTH = 1 << ABITS;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic [15:0] mem_data_in;
    logic        rd;
    logic        wr;
    logic [15:0] mem_data_out;
    logic        mfc;
    logic        busy;
    logic        req_err;

    int check_count = 0;
    int pass_count  = 0;

    logic [15:0] model_mem [DEPTH];
    bit          model_valid [DEPTH];
    logic [15:0] model_out;

    typedef struct {
        bit          is_write;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs [10];

    memory_unit #(.WAIT_CYCLES(WAIT), .ADDR_BITS(ABITS)) dut (
        .clk(clk),
        .reset(reset),
        .addr(addr),
        .mem_data_in(mem_data_in),
        .rd(rd),
        .wr(wr),
        .mem_data_out(mem_data_out),
        .mfc(mfc),
        .busy(busy),
        .req_err(req_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic r, input logic w, input logic [15:0] a,
                                 input logic [15:0] d);
        rd          = r;
        wr          = w;
        addr        = a;
        mem_data_in = d;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
        end else begin
            pass_count++;
        end
    endtask

    // Full transfer with cycle-exact handshake checks; model decides the data.
    task automatic doTransfer(input bit is_write, input logic [15:0] a, input logic [15:0] d,
                              input string tag);
        logic [ABITS-1:0] idx;
        idx = a[ABITS-1:0];
        applyStimulus(!is_write, is_write, a, d);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, a, d);
        checkOutput({tag, "_busy_accept"}, int'(busy), 1);
        for (int k = 1; k <= WAIT; k++) begin
            @(posedge clk); #1;
            if (k < WAIT) checkOutput({tag, "_mfc_early"}, int'(mfc), 0);
        end
        if (is_write) begin
            model_mem[idx]   = d;
            model_valid[idx] = 1'b1;
        end else begin
            model_out = model_mem[idx];
        end
        checkOutput({tag, "_mfc_done"}, int'(mfc), 1);
        checkOutput({tag, "_busy_done"}, int'(busy), 1);
        checkOutput({tag, "_data"}, int'(mem_data_out), int'(model_out));
        @(posedge clk); #1;
        checkOutput({tag, "_mfc_idle"}, int'(mfc), 0);
        checkOutput({tag, "_busy_idle"}, int'(busy), 0);
    endtask

    initial begin
        int got;
        int last_pulse;
        int pulses;
        int exp_pulses;
        bit op;
        logic [15:0] ra;
        logic [15:0] rdat;

        vecs[0] = '{1'b1, 16'h0005, 16'hBEEF, 16'h0000};
        vecs[1] = '{1'b0, 16'h0005, 16'h0000, 16'hBEEF};
        vecs[2] = '{1'b1, 16'h0105, 16'h1234, 16'hBEEF};
        vecs[3] = '{1'b0, 16'h0005, 16'h0000, 16'h1234};
        vecs[4] = '{1'b1, 16'h0010, 16'h5A5A, 16'h1234};
        vecs[5] = '{1'b1, 16'h0020, 16'hC3C3, 16'h1234};
        vecs[6] = '{1'b0, 16'hFF10, 16'h0000, 16'h5A5A};
        vecs[7] = '{1'b1, 16'h00FF, 16'h0001, 16'h5A5A};
        vecs[8] = '{1'b0, 16'h00FF, 16'h0000, 16'h0001};
        vecs[9] = '{1'b0, 16'h0020, 16'h0000, 16'hC3C3};

        for (int i = 0; i < DEPTH; i++) model_valid[i] = 1'b0;
        model_out = 16'h0000;

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        #2;
        checkOutput("rst_noclk_busy", int'(busy), 0);
        checkOutput("rst_noclk_data", int'(mem_data_out), 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_data", int'(mem_data_out), 0);
        checkOutput("rst_mfc", int'(mfc), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_req_err", int'(req_err), 0);
        reset = 1'b0;

        $display("[TB] table vectors");
        for (int i = 0; i < 10; i++) begin
            doTransfer(vecs[i].is_write, vecs[i].addr, vecs[i].data, "tbl");
            checkOutput("tbl_out", int'(mem_data_out), int'(vecs[i].exp_out));
        end

        $display("[TB] rd/wr conflict");
        applyStimulus(1'b1, 1'b1, 16'h0005, 16'h9999);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 16'h0005, 16'h9999);
        checkOutput("conf_req_err", int'(req_err), 1);
        checkOutput("conf_busy", int'(busy), 0);
        checkOutput("conf_mfc", int'(mfc), 0);
        @(posedge clk); #1;
        checkOutput("conf_req_err_clear", int'(req_err), 0);
        checkOutput("conf_busy_after", int'(busy), 0);
        doTransfer(1'b0, 16'h0005, 16'h0000, "conf_rd");

        $display("[TB] request ignored during access");
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b1, 16'h0010, 16'hFFFF);
        checkOutput("ign_busy", int'(busy), 1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 16'h0010, 16'hFFFF);
        got = 0;
        for (int k = 0; k < 20; k++) begin
            if (mfc === 1'b1) begin
                got = 1;
                break;
            end
            @(posedge clk); #1;
        end
        checkOutput("ign_mfc_seen", got, 1);
        model_out = model_mem[8'h10];
        checkOutput("ign_data", int'(mem_data_out), int'(model_out));
        @(posedge clk); #1;
        checkOutput("ign_idle", int'(busy), 0);
        doTransfer(1'b0, 16'h0010, 16'h0000, "ign_rd");

        $display("[TB] reset mid-write");
        applyStimulus(1'b0, 1'b1, 16'h0020, 16'hAAAA);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 16'h0020, 16'hAAAA);
        @(posedge clk); #1;
        checkOutput("mid_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        model_out = 16'h0000;
        checkOutput("mid_rst_data", int'(mem_data_out), 0);
        checkOutput("mid_rst_busy", int'(busy), 0);
        checkOutput("mid_rst_mfc", int'(mfc), 0);
        checkOutput("mid_rst_req_err", int'(req_err), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        doTransfer(1'b0, 16'h0020, 16'h0000, "mid_rd");

        $display("[TB] back-to-back reads");
        applyStimulus(1'b1, 1'b0, 16'h00FF, 16'h0000);
        last_pulse = -1;
        pulses     = 0;
        exp_pulses = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            if (c >= WAIT && ((c - WAIT) % (WAIT + 2)) == 0) exp_pulses++;
            if (mfc === 1'b1) begin
                if (last_pulse >= 0) checkOutput("b2b_gap", c - last_pulse, WAIT + 2);
                checkOutput("b2b_data", int'(mem_data_out), int'(model_mem[8'hFF]));
                last_pulse = c;
                pulses++;
            end
        end
        applyStimulus(1'b0, 1'b0, 16'h00FF, 16'h0000);
        checkOutput("b2b_pulses", pulses, exp_pulses);
        model_out = model_mem[8'hFF];
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (busy === 1'b0) begin
                got = 1;
                break;
            end
        end
        checkOutput("b2b_drain", got, 1);

        $display("[TB] randomized transfers");
        for (int i = 0; i < 40; i++) begin
            op   = 1'($urandom_range(0, 1));
            ra   = 16'($urandom);
            rdat = 16'($urandom);
            if (!op && !model_valid[ra[ABITS-1:0]]) op = 1'b1;
            doTransfer(op, ra, rdat, "rnd");
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/memory_unit.md
MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, meaning: clock cycles spent in ACCESS per transfer (legal range 1..15).
REQ-002 Parameter ADDR_BITS, default 8, meaning: word-address bits used; depth = 2^ADDR_BITS 16-bit words.
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port addr  input  16: word address, driven from MAR.
REQ-006 Port mem_data_in  input  16: write data, driven by MDR when t_mdr_mem is active.
REQ-007 Port rd  input  1: read request.
REQ-008 Port wr  input  1: write request.
REQ-009 Port mem_data_out  output  16: read data, consumed by MDR via ld_mdr_mem.
REQ-010 Port mfc  output  1: memory-function-complete; one-cycle pulse.
REQ-011 Port busy  output  1: high whenever a transfer is in progress.
REQ-012 Port req_err  output  1: one-cycle pulse flagging a rejected rd+wr request.

Function
REQ-013 The block SHALL implement the FSM states IDLE, ACCESS and DONE, encoded in registered state.
REQ-014 In IDLE with exactly one of rd/wr high at a rising edge, the block SHALL accept the request, latch addr[ADDR_BITS-1:0], mem_data_in and the direction, clear the wait counter, and enter ACCESS.
REQ-015 Upper addr bits [15:ADDR_BITS] SHALL be ignored, so addresses alias modulo depth.
REQ-016 In IDLE with rd and wr both high, the block SHALL perform no access, stay in IDLE, and pulse req_err high for the following cycle.
REQ-017 rd/wr SHALL be ignored in ACCESS and DONE; latched address/data SHALL NOT change mid-transfer.
REQ-018 ACCESS SHALL last exactly WAIT_CYCLES cycles (counter 0..WAIT_CYCLES-1), then transition to DONE.
REQ-019 On the ACCESS->DONE edge, a write SHALL store the latched data at the latched address; a read SHALL load mem_data_out from the latched address.
REQ-020 DONE SHALL last one cycle with mfc=1, then return unconditionally to IDLE.
REQ-021 mfc SHALL be high only in DONE; with acceptance at edge N, mfc is high between edges N+WAIT_CYCLES and N+WAIT_CYCLES+1.
REQ-022 busy SHALL be high in ACCESS and DONE and low in IDLE.
REQ-023 mem_data_out SHALL hold its value until the next read completes; writes SHALL NOT modify it.
REQ-024 Minimum request-to-request spacing SHALL be WAIT_CYCLES+2 cycles; a request held high through DONE is sampled in the following IDLE cycle as a new request.
REQ-025 A read of an address written by an earlier completed write SHALL return that written data (read-after-write coherent).

Reset
REQ-026 While reset is high, state SHALL be IDLE, counter 0, mem_data_out 0x0000, and mfc, busy and req_err 0, independent of clk.
REQ-027 Reset asserted mid-transfer SHALL abort the transfer; a write that has not reached the ACCESS->DONE edge SHALL NOT modify memory.
REQ-028 Memory array contents SHALL NOT be cleared by reset.

Verification
REQ-029 Write/read, WAIT_CYCLES=2: wr, addr=0x0005, data=0xBEEF at edge 0 -> busy high after edge 0, mfc high only between edges 2 and 3; then rd addr=0x0005 -> mem_data_out=0xBEEF with mfc.
REQ-030 Aliasing: write 0x1234 to addr 0x0105, then read addr 0x0005 -> 0x1234.
REQ-031 Conflict: rd=wr=1 in IDLE -> req_err pulses one cycle, busy stays 0, mfc stays 0, memory unchanged.
REQ-032 Ignored request: during ACCESS of a read of 0x0010, pulse wr with addr 0x0010 and data 0xFFFF -> read completes normally, and a later read of 0x0010 returns the prior value.
REQ-033 Reset mid-write: assert reset one cycle after accepting wr 0xAAAA to 0x0020 -> outputs zero immediately; a later read of 0x0020 returns its pre-write value.
REQ-034 Back-to-back: rd held high continuously -> mfc pulses every WAIT_CYCLES+2 cycles (every 4 cycles at WAIT_CYCLES=2).
